// File: rtl/smartwatch_pkg.sv
// Shared types and field limits for the smartwatch time/alarm editor.
package smartwatch_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SET_HOUR   = 3'd1,
    SET_MIN    = 3'd2,
    ALARM_HOUR = 3'd3,
    ALARM_MIN  = 3'd4
  } edit_mode_t;

  localparam int HOUR_W   = 5;
  localparam int MINUTE_W = 6;

  localparam logic [HOUR_W-1:0]   MAX_HOUR   = 5'd23;
  localparam logic [MINUTE_W-1:0] MAX_MINUTE = 6'd59;

  // Wrap by compare so the field can never leave its legal range.
  function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
    return (h == MAX_HOUR) ? '0 : h + HOUR_W'(1);
  endfunction

  function automatic logic [MINUTE_W-1:0] minute_inc(input logic [MINUTE_W-1:0] m);
    return (m == MAX_MINUTE) ? '0 : m + MINUTE_W'(1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw pushbutton -> 2-flop synchroniser -> debounce -> one-cycle press pulse,
// with optional hold-to-repeat pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_RATE     = 1000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic pulse_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            db_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            press_q;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_raw_i};
  end

  // Accept a new level after DEBOUNCE_CYCLES identical samples; pulse on a rising accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync_q[1] != db_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_q     <= sync_q[1];
          db_cnt_q <= '0;
          press_q  <= sync_q[1];
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  if (REPEAT_EN) begin : g_rep
    localparam int RP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [RP_W-1:0] rp_cnt_q;
    logic            rep_q;

    // Counter is zero in the press cycle (level was low before); reload shortens later periods.
    always_ff @(posedge clk) begin
      if (reset || !db_q) begin
        rp_cnt_q <= '0;
        rep_q    <= 1'b0;
      end else if (rp_cnt_q == RP_LAST) begin
        rp_cnt_q <= RP_RELOAD;
        rep_q    <= 1'b1;
      end else begin
        rp_cnt_q <= rp_cnt_q + RP_W'(1);
        rep_q    <= 1'b0;
      end
    end

    // Gate with the level so a release in the same edge cancels a pending repeat.
    assign pulse_o = press_q | (rep_q & db_q);
  end else begin : g_norep
    assign pulse_o = press_q;
  end

endmodule

// File: rtl/watch_time_setter.sv
// Button-driven editor for the set-time (with load strobe) and the alarm registers.
module watch_time_setter
  import smartwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_RATE     = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_mode_raw,
  input  logic                btn_inc_raw,
  input  logic                btn_set_raw,
  output logic [HOUR_W-1:0]   set_hours,
  output logic [MINUTE_W-1:0] set_minutes,
  output logic                time_load,
  output logic [HOUR_W-1:0]   alarm_hours,
  output logic [MINUTE_W-1:0] alarm_minutes,
  output logic [2:0]          edit_mode,
  output logic                editing
);

  logic mode_p, inc_p, set_p;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
    u_mode (.clk(clk), .reset(reset), .btn_raw_i(btn_mode_raw), .pulse_o(mode_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
    u_inc  (.clk(clk), .reset(reset), .btn_raw_i(btn_inc_raw), .pulse_o(inc_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
    u_set  (.clk(clk), .reset(reset), .btn_raw_i(btn_set_raw), .pulse_o(set_p));

  edit_mode_t          state_q;
  logic [HOUR_W-1:0]   set_h_q, set_h_d, alarm_h_q, alarm_edit_h_q, alarm_edit_h_d;
  logic [MINUTE_W-1:0] set_m_q, set_m_d, alarm_m_q, alarm_edit_m_q, alarm_edit_m_d;
  logic                load_q;

  // Field values after this cycle's inc; set/mode actions below consume these.
  always_comb begin
    set_h_d        = set_h_q;
    set_m_d        = set_m_q;
    alarm_edit_h_d = alarm_edit_h_q;
    alarm_edit_m_d = alarm_edit_m_q;
    if (inc_p) begin
      case (state_q)
        SET_HOUR:   set_h_d        = hour_inc(set_h_q);
        SET_MIN:    set_m_d        = minute_inc(set_m_q);
        ALARM_HOUR: alarm_edit_h_d = hour_inc(alarm_edit_h_q);
        ALARM_MIN:  alarm_edit_m_d = minute_inc(alarm_edit_m_q);
        default: ;
      endcase
    end
  end

  // Edit FSM: set has priority over mode; entering ALARM_HOUR loads the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      set_h_q        <= '0;
      set_m_q        <= '0;
      alarm_h_q      <= '0;
      alarm_m_q      <= '0;
      alarm_edit_h_q <= '0;
      alarm_edit_m_q <= '0;
      load_q         <= 1'b0;
    end else begin
      load_q         <= 1'b0;
      set_h_q        <= set_h_d;
      set_m_q        <= set_m_d;
      alarm_edit_h_q <= alarm_edit_h_d;
      alarm_edit_m_q <= alarm_edit_m_d;
      if (set_p) begin
        case (state_q)
          SET_HOUR, SET_MIN: begin
            load_q  <= 1'b1;
            state_q <= IDLE;
          end
          ALARM_HOUR, ALARM_MIN: begin
            alarm_h_q <= alarm_edit_h_d;
            alarm_m_q <= alarm_edit_m_d;
            state_q   <= IDLE;
          end
          default: ;
        endcase
      end else if (mode_p) begin
        case (state_q)
          IDLE:       state_q <= SET_HOUR;
          SET_HOUR:   state_q <= SET_MIN;
          SET_MIN: begin
            state_q        <= ALARM_HOUR;
            alarm_edit_h_q <= alarm_h_q;
            alarm_edit_m_q <= alarm_m_q;
          end
          ALARM_HOUR: state_q <= ALARM_MIN;
          default:    state_q <= IDLE;
        endcase
      end
    end
  end

  assign set_hours     = set_h_q;
  assign set_minutes   = set_m_q;
  assign time_load     = load_q;
  assign alarm_hours   = alarm_h_q;
  assign alarm_minutes = alarm_m_q;
  assign edit_mode     = state_q;
  assign editing       = (state_q != IDLE);

endmodule

// File: tb/tb_watch_time_setter.sv
// Randomised and directed bench for watch_time_setter against a field-level model.
module tb_watch_time_setter;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RR = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bm = 1'b0, bi = 1'b0, bs = 1'b0;
  logic [4:0] set_hours, alarm_hours;
  logic [5:0] set_minutes, alarm_minutes;
  logic       time_load, editing;
  logic [2:0] edit_mode;

  always #5 clk = ~clk;

  watch_time_setter #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset),
    .btn_mode_raw(bm), .btn_inc_raw(bi), .btn_set_raw(bs),
    .set_hours(set_hours), .set_minutes(set_minutes), .time_load(time_load),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .edit_mode(edit_mode), .editing(editing)
  );

  int tests = 0;
  int fails = 0;

  // strobe monitor
  int         load_cnt = 0;
  int         consec = 0;
  logic       prev_load = 1'b0;
  logic [4:0] last_h = '0;
  logic [5:0] last_m = '0;

  always @(negedge clk) begin
    if (time_load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      last_h   <= set_hours;
      last_m   <= set_minutes;
      if (prev_load) consec <= consec + 1;
    end
    prev_load <= (time_load === 1'b1);
  end

  // reference model: state index 0..4 = idle, time hour, time minute, alarm hour, alarm minute
  int m_state = 0, m_h = 0, m_m = 0, m_ah = 0, m_am = 0, m_sh = 0, m_sm = 0;
  int m_loads = 0, m_lh = 0, m_lm = 0;

  function automatic void model_reset();
    m_state = 0; m_h = 0; m_m = 0; m_ah = 0; m_am = 0; m_sh = 0; m_sm = 0;
  endfunction

  function automatic void model_apply(input bit mo, input bit in, input bit se);
    if (in) begin
      if (m_state == 1) m_h  = (m_h + 1) % 24;
      if (m_state == 2) m_m  = (m_m + 1) % 60;
      if (m_state == 3) m_sh = (m_sh + 1) % 24;
      if (m_state == 4) m_sm = (m_sm + 1) % 60;
    end
    if (se) begin
      if (m_state == 1 || m_state == 2) begin
        m_loads++; m_lh = m_h; m_lm = m_m; m_state = 0;
      end else if (m_state >= 3) begin
        m_ah = m_sh; m_am = m_sm; m_state = 0;
      end
    end else if (mo) begin
      m_state = (m_state + 1) % 5;
      if (m_state == 3) begin m_sh = m_ah; m_sm = m_am; end
    end
  endfunction

  // number of inc events when the debounced level stays high for h cycles
  function automatic int n_inc(input int h);
    int n = 1;
    for (int t = RD; t < h; t += RR) n++;
    return n;
  endfunction

  function automatic logic [25:0] exp_vec();
    return {3'(m_state), 1'(m_state != 0), 5'(m_h), 6'(m_m), 5'(m_ah), 6'(m_am)};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {edit_mode, editing, set_hours, set_minutes, alarm_hours, alarm_minutes};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // raw buttons held clean for 'hold' cycles, then released long enough to settle
  task automatic press(input bit mo, input bit in, input bit se, input int hold);
    bm = mo; bi = in; bs = se;
    tick(hold);
    bm = 1'b0; bi = 1'b0; bs = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    reset = 1'b1; bm = 1'b1; bi = 1'b1; bs = 1'b1;
    tick(2);
    tests++;
    if (dut_vec() !== 26'd0 || time_load !== 1'b0) begin
      $display("FAIL reset_hold got=%h load=%b want=0", dut_vec(), time_load); fails++;
    end
    reset = 1'b0; bm = 1'b0; bi = 1'b0; bs = 1'b0;
    tick(12);
    tests++;
    if (dut_vec() !== exp_vec() || load_cnt !== 0) begin
      $display("FAIL reset_release got=%h loads=%0d want=%h loads=0", dut_vec(), load_cnt, exp_vec()); fails++;
    end
  endtask

  task automatic test_debounce();
    bm = 1'b1;
    tick(6);
    tests++;
    if (edit_mode !== 3'd0) begin
      $display("FAIL latency_early got=%0d want=0", edit_mode); fails++;
    end
    tick(1);
    tests++;
    if (edit_mode !== 3'd1) begin
      $display("FAIL latency_exact got=%0d want=1", edit_mode); fails++;
    end
    tick(3);
    bm = 1'b0;
    tick(10);
    model_apply(1'b1, 1'b0, 1'b0);
    bi = 1'b1; tick(3); bi = 1'b0; tick(10);
    for (int i = 0; i < 20; i++) begin
      bi = ((i % 4) != 3); tick(1);
    end
    bi = 1'b0; tick(10);
    tests++;
    if (dut_vec() !== exp_vec()) begin
      $display("FAIL bounce got=%h want=%h", dut_vec(), exp_vec()); fails++;
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 23; i++) begin
      press(1'b0, 1'b1, 1'b0, 8); model_apply(1'b0, 1'b1, 1'b0);
    end
    tests++;
    if (set_hours !== 5'd23 || dut_vec() !== exp_vec()) begin
      $display("FAIL hour_23 got=%h want=%h", dut_vec(), exp_vec()); fails++;
    end
    press(1'b0, 1'b1, 1'b0, 8); model_apply(1'b0, 1'b1, 1'b0);
    tests++;
    if (set_hours !== 5'd0 || set_minutes !== 6'd0 || dut_vec() !== exp_vec()) begin
      $display("FAIL hour_wrap got=%h want=%h", dut_vec(), exp_vec()); fails++;
    end
  endtask

  task automatic test_repeat();
    press(1'b1, 1'b0, 1'b0, 8); model_apply(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 40);
    repeat (n_inc(40)) model_apply(1'b0, 1'b1, 1'b0);
    tests++;
    if (set_minutes !== 6'd7 || dut_vec() !== exp_vec()) begin
      $display("FAIL repeat_40 got=%h want=%h", dut_vec(), exp_vec()); fails++;
    end
    for (int i = 0; i < 4; i++) begin
      int h;
      h = $urandom_range(6, 70);
      press(1'b0, 1'b1, 1'b0, h);
      repeat (n_inc(h)) model_apply(1'b0, 1'b1, 1'b0);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL repeat_hold%0d got=%h want=%h", h, dut_vec(), exp_vec()); fails++;
      end
    end
  endtask

  task automatic test_commit();
    int l0;
    press(1'b0, 1'b0, 1'b1, 8); model_apply(1'b0, 1'b0, 1'b1);
    tests++;
    if (load_cnt !== m_loads || last_m !== 6'(m_lm) || dut_vec() !== exp_vec()) begin
      $display("FAIL min_commit got=%h loads=%0d m=%0d want=%h loads=%0d m=%0d",
               dut_vec(), load_cnt, last_m, exp_vec(), m_loads, m_lm); fails++;
    end
    press(1'b1, 1'b0, 1'b0, 8); model_apply(1'b1, 1'b0, 1'b0);
    while (m_h != 7) begin
      press(1'b0, 1'b1, 1'b0, 8); model_apply(1'b0, 1'b1, 1'b0);
    end
    l0 = load_cnt;
    press(1'b1, 1'b0, 1'b1, 8); model_apply(1'b1, 1'b0, 1'b1);
    tests++;
    if (load_cnt !== l0 + 1 || last_h !== 5'd7 || edit_mode !== 3'd0 || dut_vec() !== exp_vec()) begin
      $display("FAIL set_beats_mode got=%h loads=%0d h=%0d want=%h loads=%0d h=7",
               dut_vec(), load_cnt, last_h, exp_vec(), l0 + 1); fails++;
    end
  endtask

  task automatic alarm_edit();
    repeat (3) begin press(1'b1, 1'b0, 1'b0, 8); model_apply(1'b1, 1'b0, 1'b0); end
    repeat (6) begin press(1'b0, 1'b1, 1'b0, 8); model_apply(1'b0, 1'b1, 1'b0); end
    press(1'b1, 1'b0, 1'b0, 8); model_apply(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 130);
    repeat (n_inc(130)) model_apply(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_alarm();
    int l0;
    alarm_edit();
    l0 = load_cnt;
    reset = 1'b1; tick(2); reset = 1'b0; model_reset(); tick(2);
    tests++;
    if (dut_vec() !== 26'd0 || load_cnt !== l0) begin
      $display("FAIL reset_mid_edit got=%h loads=%0d want=0 loads=%0d", dut_vec(), load_cnt, l0); fails++;
    end
    alarm_edit();
    press(1'b0, 1'b0, 1'b1, 8); model_apply(1'b0, 1'b0, 1'b1);
    tests++;
    if ({alarm_hours, alarm_minutes} !== {5'd6, 6'd30} || dut_vec() !== exp_vec()) begin
      $display("FAIL alarm_commit got=%h want=%h (6:30)", dut_vec(), exp_vec()); fails++;
    end
    repeat (4) begin press(1'b1, 1'b0, 1'b0, 8); model_apply(1'b1, 1'b0, 1'b0); end
    press(1'b0, 1'b1, 1'b0, 8); model_apply(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0, 8); model_apply(1'b1, 1'b0, 1'b0);
    tests++;
    if ({alarm_hours, alarm_minutes} !== {5'd6, 6'd30} || dut_vec() !== exp_vec()) begin
      $display("FAIL alarm_discard got=%h want=%h", dut_vec(), exp_vec()); fails++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int r, h;
      bit se;
      r = $urandom_range(0, 5);
      case (r)
        0: begin press(1'b1, 1'b0, 1'b0, 8); model_apply(1'b1, 1'b0, 1'b0); end
        1: begin press(1'b0, 1'b1, 1'b0, 8); model_apply(1'b0, 1'b1, 1'b0); end
        2: begin press(1'b0, 1'b0, 1'b1, 8); model_apply(1'b0, 1'b0, 1'b1); end
        3: begin press(1'b1, 1'b0, 1'b1, 8); model_apply(1'b1, 1'b0, 1'b1); end
        4: begin
          se = 1'($urandom_range(0, 1));
          press(!se, 1'b1, se, 8); model_apply(!se, 1'b1, se);
        end
        default: begin
          h = $urandom_range(17, 45);
          press(1'b0, 1'b1, 1'b0, h);
          repeat (n_inc(h)) model_apply(1'b0, 1'b1, 1'b0);
        end
      endcase
      tests++;
      if (dut_vec() !== exp_vec() || load_cnt !== m_loads ||
          (m_loads > 0 && {last_h, last_m} !== {5'(m_lh), 6'(m_lm)})) begin
        $display("FAIL random_%0d op=%0d got=%h loads=%0d load_val=%0d:%0d want=%h loads=%0d load_val=%0d:%0d",
                 i, r, dut_vec(), load_cnt, last_h, last_m, exp_vec(), m_loads, m_lh, m_lm);
        fails++;
      end
    end
  endtask

  task automatic test_strobe_width();
    tests++;
    if (consec !== 0) begin
      $display("FAIL load_consecutive got=%0d want=0", consec); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_wrap();
    test_repeat();
    test_commit();
    test_alarm();
    test_random();
    test_strobe_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
